// File: rtl/mem_line_server_if.sv
// Cache-controller <-> main-memory link: request side driven by the cache,
// beat/ack side driven by the memory server.
interface mem_line_server_if #(
    parameter int ADR_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WORD_OFFSET = 2
);
    logic                   req_cc2mem;
    logic [ADR_WIDTH-1:0]   adr_cc2mem;
    logic                   rdwr_cc2mem;
    logic [DATA_WIDTH-1:0]  dat_cc2mem;
    logic                   ack_mem2cc;
    logic [DATA_WIDTH-1:0]  dat_mem2cc;
    logic [WORD_OFFSET-1:0] word_mem2cc;

    modport master (
        output req_cc2mem, adr_cc2mem, rdwr_cc2mem, dat_cc2mem,
        input  ack_mem2cc, dat_mem2cc, word_mem2cc
    );

    modport slave (
        input  req_cc2mem, adr_cc2mem, rdwr_cc2mem, dat_cc2mem,
        output ack_mem2cc, dat_mem2cc, word_mem2cc
    );
endinterface

// File: rtl/mem_line_server.sv
// Main-memory model: serves critical-word-first line refills as timed single-word
// beats and performs single-word writes, one transaction at a time.
module mem_line_server #(
    parameter int ADR_WIDTH      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_OFFSET    = 2,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int FIRST_LATENCY  = 4,
    parameter int BEAT_GAP       = 3
) (
    input  logic               clk,
    input  logic               rst,
    mem_line_server_if.slave   bus
);
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [WORD_OFFSET-1:0]    beat_q, beat_d;
    logic [MEM_DEPTH_LOG2-1:0] idx_q;
    logic                      rdwr_q;
    logic [DATA_WIDTH-1:0]     wdat_q;
    logic                      ack_q;
    logic [WORD_OFFSET-1:0]    word_q;
    logic [DATA_WIDTH-1:0]     rd_q;
    logic                      accept;
    logic                      emit;
    logic [WORD_OFFSET-1:0]    word_cur;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx;

    logic [DATA_WIDTH-1:0]     mem [2**MEM_DEPTH_LOG2];

    // Beat k of a refill targets word (w + k) mod line size, wrapping inside the line.
    assign word_cur = idx_q[WORD_OFFSET-1:0] + beat_q;
    assign rd_idx   = {idx_q[MEM_DEPTH_LOG2-1:WORD_OFFSET], word_cur};
    assign accept   = (state_q == S_IDLE) && bus.req_cc2mem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        emit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_cc2mem) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(FIRST_LATENCY - 1);
                    beat_d  = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    emit    = 1'b1;
                    state_d = S_BEAT;
                    beat_d  = beat_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BEAT: begin
                // beat_q has wrapped back to zero once the last word was emitted.
                if (rdwr_q || (beat_q == '0)) begin
                    state_d = S_DONE;
                end else if (BEAT_GAP == 0) begin
                    emit   = 1'b1;
                    beat_d = beat_q + 1'b1;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(BEAT_GAP - 1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    emit    = 1'b1;
                    state_d = S_BEAT;
                    beat_d  = beat_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.req_cc2mem) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            rdwr_q  <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            ack_q   <= emit;
            word_q  <= emit ? word_cur : '0;
            if (accept) begin
                idx_q  <= bus.adr_cc2mem[MEM_DEPTH_LOG2+1:2];
                rdwr_q <= bus.rdwr_cc2mem;
                wdat_q <= bus.dat_cc2mem;
            end
        end
    end

    // Array holds its contents across reset; a write cut off by rst is dropped.
    always_ff @(posedge clk) begin
        if (emit && rdwr_q && !rst) begin
            mem[idx_q] <= wdat_q;
        end
        rd_q <= mem[rd_idx];
    end

    assign bus.ack_mem2cc  = ack_q;
    assign bus.word_mem2cc = word_q;
    assign bus.dat_mem2cc  = ack_q ? (rdwr_q ? wdat_q : rd_q) : '0;
endmodule

// File: tb/tb_mem_line_server.sv
// Scoreboard bench for mem_line_server: stimulus queues expected beats with their
// arrival cycle, a negedge monitor pops and compares every ack.
module tb_mem_line_server;
    localparam int FL = 4;
    localparam int BG = 3;

    typedef struct {
        int unsigned at;
        logic [1:0]  word;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [31:0] model [1024];

    mem_line_server_if #(.ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2)) bus ();

    mem_line_server #(
        .ADR_WIDTH(32), .DATA_WIDTH(32), .WORD_OFFSET(2),
        .MEM_DEPTH_LOG2(10), .FIRST_LATENCY(FL), .BEAT_GAP(BG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ack must match the head of the scoreboard; idle cycles must be zero.
    always @(negedge clk) begin
        if (bus.ack_mem2cc === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack cyc=%0d word=%0d dat=%08h", cyc, bus.word_mem2cc, bus.dat_mem2cc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (cyc != e.at) begin
                    failures++;
                    $display("FAIL beat_cycle got=%0d exp=%0d", cyc, e.at);
                end
                checks++;
                if (bus.word_mem2cc !== e.word) begin
                    failures++;
                    $display("FAIL beat_word got=%0d exp=%0d", bus.word_mem2cc, e.word);
                end
                checks++;
                if (bus.dat_mem2cc !== e.dat) begin
                    failures++;
                    $display("FAIL beat_data got=%08h exp=%08h", bus.dat_mem2cc, e.dat);
                end
                $display("beat cyc=%0d word=%0d dat=%08h", cyc, bus.word_mem2cc, bus.dat_mem2cc);
            end
        end else begin
            checks++;
            if (bus.dat_mem2cc !== 32'h0 || bus.word_mem2cc !== 2'd0 || bus.ack_mem2cc !== 1'b0) begin
                failures++;
                $display("FAIL idle_zero cyc=%0d ack=%b dat=%08h word=%0d", cyc, bus.ack_mem2cc,
                         bus.dat_mem2cc, bus.word_mem2cc);
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic rw, input logic [31:0] d,
                         output int unsigned e0);
        @(negedge clk);
        bus.req_cc2mem  = 1'b1;
        bus.adr_cc2mem  = a;
        bus.rdwr_cc2mem = rw;
        bus.dat_cc2mem  = d;
        @(posedge clk);
        #1 e0 = cyc;
    endtask

    task automatic push_read(input logic [31:0] a, input int unsigned e0, input int nbeats);
        logic [1:0] w;
        logic [1:0] wk;
        logic [7:0] base;
        exp_t       e;
        w    = a[3:2];
        base = a[11:4];
        for (int k = 0; k < nbeats; k++) begin
            wk     = w + 2'(k);
            e.at   = e0 + FL + k * (BG + 1);
            e.word = wk;
            e.dat  = model[{base, wk}];
            sb_q.push_back(e);
        end
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input int unsigned e0);
        exp_t e;
        model[a[11:2]] = d;
        e.at   = e0 + FL;
        e.word = a[3:2];
        e.dat  = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_beats got_pending=%0d exp=0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic txn(input string name, input logic [31:0] a, input logic rw, input logic [31:0] d);
        int unsigned e0;
        start(a, rw, d, e0);
        if (rw) push_write(a, d, e0);
        else    push_read(a, e0, 4);
        @(negedge clk);
        bus.req_cc2mem = 1'b0;
        wait_drain(name, 80);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int unsigned e0;
        for (int i = 0; i < 1024; i++) model[i] = 32'h0;

        // 1: reset held with a pending request
        rst             = 1'b1;
        bus.req_cc2mem  = 1'b1;
        bus.adr_cc2mem  = 32'h100;
        bus.rdwr_cc2mem = 1'b0;
        bus.dat_cc2mem  = 32'h0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.ack_mem2cc !== 1'b0 || bus.dat_mem2cc !== 32'h0 || bus.word_mem2cc !== 2'd0) begin
                failures++;
                $display("FAIL reset_outputs ack=%b dat=%08h word=%0d exp=0/0/0",
                         bus.ack_mem2cc, bus.dat_mem2cc, bus.word_mem2cc);
            end
        end
        rst            = 1'b0;
        bus.req_cc2mem = 1'b0;
        repeat (4) @(negedge clk);

        // 2: single write, then refill of its line from a zeroed array
        txn("write_108", 32'h0000_0108, 1'b1, 32'h015F_DF1E);
        txn("read_100_a", 32'h0000_0100, 1'b0, 32'h0);

        // 3: fill the line and read it aligned
        txn("write_100", 32'h0000_0100, 1'b1, 32'h1111_1111);
        txn("write_104", 32'h0000_0104, 1'b1, 32'h2222_2222);
        txn("write_108b", 32'h0000_0108, 1'b1, 32'h3333_3333);
        txn("write_10c", 32'h0000_010C, 1'b1, 32'h4444_4444);
        txn("read_100_b", 32'h0000_0100, 1'b0, 32'h0);

        // 4: critical word last in line, aliased address
        txn("read_110c", 32'h0000_110C, 1'b0, 32'h0);

        // 5: request held high past completion must not retrigger
        start(32'h0000_0100, 1'b0, 32'h0, e0);
        push_read(32'h0000_0100, e0, 4);
        wait_drain("held_req", 80);
        repeat (10) @(negedge clk);
        bus.req_cc2mem = 1'b0;
        start(32'h0000_0104, 1'b0, 32'h0, e0);
        push_read(32'h0000_0104, e0, 4);
        @(negedge clk);
        bus.req_cc2mem = 1'b0;
        wait_drain("read_104", 80);
        repeat (3) @(negedge clk);

        // 6: reset after the second beat aborts the burst
        start(32'h0000_0100, 1'b0, 32'h0, e0);
        push_read(32'h0000_0100, e0, 2);
        @(negedge clk);
        bus.req_cc2mem = 1'b0;
        for (int i = 0; i < 100 && cyc < e0 + FL + BG + 1; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        wait_drain("abort_burst", 5);
        txn("read_100_c", 32'h0000_0100, 1'b0, 32'h0);

        // 7: a write cut off by reset before its beat leaves the array untouched
        start(32'h0000_0104, 1'b1, 32'hDEAD_BEEF, e0);
        @(negedge clk);
        bus.req_cc2mem = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        txn("read_100_d", 32'h0000_0100, 1'b0, 32'h0);

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d exp=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule
